mask_sequencer: RTL and testbench
=================================

// Module: mask_sequencer
// PURPOSE
//   Time-sequenced mask controller for the clock-gated signal outputs.
//   Holds a small table of {8-bit mask, dwell} entries and steps through them.
//   Drives the 8-bit lane mask that selects which divided clocks reach uo_out.
//   Replaces the static ui_in mask with a programmable, self-timed pattern.
// PARAMETERS
//   DEPTH   8    table entries (power of 2, >=2); AW = $clog2(DEPTH)
//   DW      16   dwell counter width; entry held dwell+1 cycles
// PORTS
//   clk        in   1    clock clk
//   reset      in   1    reset reset, synchronous, active-high
//   wr_en      in   1    table write strobe
//   wr_addr    in   AW   table write index
//   wr_mask    in   8    mask to store
//   wr_dwell   in   DW   dwell to store
//   last_idx   in   AW   final entry index of the sequence (sampled at start)
//   start      in   1    begin sequence (honoured in IDLE only)
//   stop       in   1    abort to IDLE
//   hold       in   1    level; freezes dwell count and index while RUN
//   mask_out   out  8    registered lane mask to gating datapath
//   busy       out  1    1 in RUN or HOLD
//   done       out  1    one-cycle pulse at natural sequence end
//   cur_idx    out  AW   entry currently driving mask_out
// BEHAVIOUR
//   Reset: state IDLE; mask_out=0, busy=0, done=0, cur_idx=0, dwell cnt=0,
//     latched last_idx=0, all table entries cleared to {0,0}; mid-run reset aborts same edge.
//   States: IDLE, RUN, HOLD.
//   IDLE: mask_out=0. start & !stop -> RUN; latch last_idx; cur_idx=0;
//     cnt=dwell[0]; mask_out=mask[0] on that same edge (1-cycle latency start->mask).
//   RUN: cnt!=0 -> cnt-=1. cnt==0 -> advance: cur_idx+1, reload cnt and mask
//     from new entry on the same edge. Entry i visible exactly dwell[i]+1 cycles.
//   RUN & hold -> HOLD (cnt/idx/mask frozen that edge); HOLD & !hold -> RUN.
//   End: cnt==0 & cur_idx==latched last_idx -> see CONFIGURATION.
//   stop: highest priority in RUN/HOLD; next edge IDLE, mask_out=0, busy=0,
//     done NOT pulsed. stop & start together in IDLE: stay IDLE.
//   start while busy: ignored. last_idx changes while busy: ignored.
//   Writes: accepted in any state; entry read on same edge as write sees OLD
//     value; write to wr_addr > last_idx is stored but unused this run.
//   Counters: cnt unsigned DW bits, never wraps (reloaded at 0); cur_idx
//     AW bits, wraps only via loop path.
// CONFIGURATION
//   MASK_SEQ_LOOP_EN defined: at end, cur_idx->0, reload entry 0, stay RUN;
//     done pulses once per completed pass; busy stays 1 until stop.
//   MASK_SEQ_LOOP_EN undefined: at end, -> IDLE, mask_out=0, busy=0, done=1
//     for exactly one cycle (the first IDLE cycle).
// STRUCTURE
//   mask_seq_pkg: state enum {IDLE,RUN,HOLD}; MASK_W=8; default DEPTH/DW.
//   Sub-module mask_seq_table: DEPTH x (8+DW) register file, sync reset clear,
//     1 write port, 1 combinational read port (read-before-write).
//   Top: FSM + dwell counter + index register + output registers.
// TESTING
//   Reset values: assert reset 2 cycles mid-RUN -> mask_out=0,busy=0,cur_idx=0 next edge.
//   Basic: entries {0x01,d=2},{0x0F,d=0},{0x80,d=1}, last_idx=2, start ->
//     mask_out 01,01,01,0F,80,80 then 00; done=1 on first 00 cycle (no loop).
//   Hold: same table, hold high 4 cycles during entry 0 -> entry 0 visible 7 cycles.
//   Stop: stop on 2nd cycle of entry 2 -> mask_out=00 next edge, done stays 0.
//   Write/read collision: write entry 1 mask=0xAA on advance edge to 1 ->
//     0x0F shown; next run shows 0xAA.
//   Loop (MASK_SEQ_LOOP_EN): last_idx=1, d=0 both -> 01,0F,01,0F...; done each pass.

Source files
------------

// File: rtl/mask_seq_pkg.sv
// Shared types and defaults for the mask sequencer: state enum, lane mask width,
// default table geometry.
package mask_seq_pkg;

  localparam int MASK_W    = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_DW    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mask_sequencer_if.sv
// Bundle of table-write, sequence-control and mask-output signals of the sequencer.
// master = whoever programs and controls the sequencer, slave = the sequencer itself.
interface mask_sequencer_if #(
  parameter int AW = 3,
  parameter int DW = 16
);
  import mask_seq_pkg::*;

  // Control handshake: start is a request that is taken only on an edge where busy is
  // low and stop is low; busy acts as the inverted ready. stop is accepted in any state
  // and always wins. done is a one-cycle completion pulse, hold is a level.
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [MASK_W-1:0] wr_mask;
  logic [DW-1:0]     wr_dwell;
  logic [AW-1:0]     last_idx;
  logic              start;
  logic              stop;
  logic              hold;
  logic [MASK_W-1:0] mask_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     cur_idx;

  modport master (
    output wr_en, wr_addr, wr_mask, wr_dwell, last_idx, start, stop, hold,
    input  mask_out, busy, done, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_mask, wr_dwell, last_idx, start, stop, hold,
    output mask_out, busy, done, cur_idx
  );

endinterface

// File: rtl/mask_seq_table.sv
// DEPTH x {mask, dwell} register file: one synchronous write port, one combinational
// read port that returns the pre-write contents on a same-edge collision.
module mask_seq_table
  import mask_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DW-1:0]     wr_dwell,
  input  logic [AW-1:0]     rd_addr,
  output logic [MASK_W-1:0] rd_mask,
  output logic [DW-1:0]     rd_dwell
);

  logic [MASK_W-1:0] mask_mem  [DEPTH];
  logic [DW-1:0]     dwell_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_mem[i]  <= '0;
        dwell_mem[i] <= '0;
      end
    end else if (wr_en) begin
      mask_mem[wr_addr]  <= wr_mask;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  assign rd_mask  = mask_mem[rd_addr];
  assign rd_dwell = dwell_mem[rd_addr];

endmodule

// File: rtl/mask_sequencer.sv
// Self-timed lane-mask sequencer: steps through {mask, dwell} table entries, holding
// each dwell+1 cycles. Define MASK_SEQ_LOOP_EN to wrap to entry 0 instead of stopping.
module mask_sequencer
  import mask_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   reset,
  mask_sequencer_if.slave bus,
  output state_t state
);

  logic [DW-1:0]     cnt;
  logic [AW-1:0]     cur_idx;
  logic [AW-1:0]     last_q;
  logic [MASK_W-1:0] mask_q;
  logic              done_q;

  logic [AW-1:0]     rd_addr;
  logic [MASK_W-1:0] rd_mask;
  logic [DW-1:0]     rd_dwell;
  logic              at_end;

  mask_seq_table #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_mask  (bus.wr_mask),
    .wr_dwell (bus.wr_dwell),
    .rd_addr  (rd_addr),
    .rd_mask  (rd_mask),
    .rd_dwell (rd_dwell)
  );

  assign at_end = (cnt == '0) && (cur_idx == last_q);

  // The single read port always looks at the entry that the next load would need.
  always_comb begin
    rd_addr = cur_idx + AW'(1);
    if (state == IDLE || at_end) rd_addr = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state   <= RUN;
            last_q  <= bus.last_idx;
            cur_idx <= '0;
            cnt     <= rd_dwell;
            mask_q  <= rd_mask;
          end
        end
        default: begin
          if (bus.stop) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_idx <= '0;
            mask_q  <= '0;
          end else if (bus.hold) begin
            state <= HOLD;
          end else begin
            // Leaving HOLD counts this edge, so a hold of N cycles stretches by N.
            state <= RUN;
            if (cnt != '0) begin
              cnt <= cnt - DW'(1);
            end else if (cur_idx == last_q) begin
`ifdef MASK_SEQ_LOOP_EN
              cur_idx <= '0;
              cnt     <= rd_dwell;
              mask_q  <= rd_mask;
              done_q  <= 1'b1;
`else
              state   <= IDLE;
              cur_idx <= '0;
              mask_q  <= '0;
              done_q  <= 1'b1;
`endif
            end else begin
              cur_idx <= cur_idx + AW'(1);
              cnt     <= rd_dwell;
              mask_q  <= rd_mask;
            end
          end
        end
      endcase
    end
  end

  assign bus.mask_out = mask_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.cur_idx  = cur_idx;

endmodule

// File: tb/tb_mask_sequencer.sv
// Directed bench for mask_sequencer: an entry-visibility model checked every cycle,
// plus literal mask traces for the basic, hold, stop, collision, loop and reset cases.
module tb_mask_sequencer;
  import mask_seq_pkg::*;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic   clk = 1'b0;
  logic   reset;
  state_t state;
  logic   cmp_en = 1'b0;
  int     n_checks = 0;
  int     n_pass = 0;

  mask_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  mask_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- model ----------------
  // Tracks which entry is visible and how many more cycles it stays visible.
  logic [7:0] tbl_mask [DEPTH];
  int         tbl_dwell [DEPTH];
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_mask = 8'h00;
  logic [2:0] m_idx = 3'd0;
  logic [2:0] m_last = 3'd0;
  int         m_left = 0;

  always @(posedge clk) begin
    logic nd;
    nd = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_mask = 8'h00; m_idx = 3'd0; m_last = 3'd0; m_left = 0;
      for (int i = 0; i < DEPTH; i++) begin tbl_mask[i] = 8'h00; tbl_dwell[i] = 0; end
    end else begin
      if (!m_busy) begin
        if (bus.start && !bus.stop) begin
          m_busy = 1'b1; m_last = bus.last_idx; m_idx = 3'd0;
          m_mask = tbl_mask[0]; m_left = tbl_dwell[0] + 1;
        end
      end else if (bus.stop) begin
        m_busy = 1'b0; m_mask = 8'h00; m_idx = 3'd0;
      end else if (!bus.hold) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_idx == m_last) begin
            nd = 1'b1;
`ifdef MASK_SEQ_LOOP_EN
            m_idx = 3'd0; m_mask = tbl_mask[0]; m_left = tbl_dwell[0] + 1;
`else
            m_busy = 1'b0; m_mask = 8'h00; m_idx = 3'd0;
`endif
          end else begin
            m_idx = m_idx + 3'd1;
            m_mask = tbl_mask[m_idx]; m_left = tbl_dwell[m_idx] + 1;
          end
        end
      end
      if (bus.wr_en) begin
        tbl_mask[bus.wr_addr]  = bus.wr_mask;
        tbl_dwell[bus.wr_addr] = int'(bus.wr_dwell);
      end
    end
    m_done = nd;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mask_out", 32'(bus.mask_out), 32'(m_mask));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("state_idle", 32'(state == IDLE), 32'(!m_busy));
      if (m_busy) check("cur_idx", 32'(bus.cur_idx), 32'(m_idx));
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] trace[$];
  logic       dtrace[$];
  logic [7:0] exp_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_entry(input int a, input logic [7:0] m, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_mask = m; bus.wr_dwell = 16'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_run(input int li);
    bus.last_idx = 3'(li); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic capture(input int n);
    trace.delete(); dtrace.delete();
    for (int i = 0; i < n; i++) begin
      trace.push_back(bus.mask_out); dtrace.push_back(bus.done);
      if (i < n - 1) tick();
    end
  endtask

  task automatic to_idle();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0; tick();
  endtask

  task automatic check_trace(input string name);
    for (int i = 0; i < trace.size(); i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check(name, 32'(trace[i]), 32'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lead;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_dwell = '0;
    bus.last_idx = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    tick(); tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    check("rst_mask", 32'(bus.mask_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_cur_idx", 32'(bus.cur_idx), 32'h0);

    // start and stop together in IDLE: stays idle
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_idle", 32'(bus.busy), 32'h0);

    // basic three-entry sequence
    write_entry(0, 8'h01, 2); write_entry(1, 8'h0F, 0); write_entry(2, 8'h80, 1);
    start_run(2); capture(8);
`ifdef MASK_SEQ_LOOP_EN
    exp_q = '{8'h01, 8'h01, 8'h01, 8'h0F, 8'h80, 8'h80, 8'h01, 8'h01};
`else
    exp_q = '{8'h01, 8'h01, 8'h01, 8'h0F, 8'h80, 8'h80, 8'h00, 8'h00};
`endif
    check_trace("basic_mask");
    check("basic_done_before", 32'(dtrace[5]), 32'h0);
    check("basic_done_end", 32'(dtrace[6]), 32'h1);
    check("basic_done_after", 32'(dtrace[7]), 32'h0);
    to_idle();

    // hold for 4 cycles during entry 0; start/last_idx pokes while busy are ignored
    start_run(2);
    trace.delete(); trace.push_back(bus.mask_out);
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); trace.push_back(bus.mask_out);
      if (i == 0) check("hold_state", 32'(state == HOLD), 32'h1);
    end
    bus.hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 0); bus.last_idx = (i == 0) ? 3'd0 : 3'd2;
      tick(); trace.push_back(bus.mask_out);
    end
    bus.start = 1'b0;
    lead = 0;
    while (lead < trace.size() && trace[lead] == 8'h01) lead++;
    check("hold_entry0_cycles", 32'(lead), 32'd7);
    check("hold_next_entry", 32'(trace[7]), 32'h0F);
    to_idle();

    // stop on the second cycle of entry 2, which is also its natural end
    start_run(2);
    for (int i = 0; i < 5; i++) tick();
    check("stop_pre_mask", 32'(bus.mask_out), 32'h80);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("stop_mask", 32'(bus.mask_out), 32'h00);
    check("stop_busy", 32'(bus.busy), 32'h0);
    check("stop_done", 32'(bus.done), 32'h0);
    tick();
    check("stop_done_late", 32'(bus.done), 32'h0);

    // write entry 1 on the edge that advances into it: old value shown this run
    start_run(2); tick(); tick();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_mask = 8'hAA; bus.wr_dwell = 16'd0;
    tick(); bus.wr_en = 1'b0;
    check("collide_old", 32'(bus.mask_out), 32'h0F);
    to_idle();
    start_run(2); tick(); tick(); tick();
    check("collide_new", 32'(bus.mask_out), 32'hAA);
    to_idle();

    // two zero-dwell entries, last_idx = 1
    write_entry(0, 8'h01, 0); write_entry(1, 8'h0F, 0);
    start_run(1); capture(6);
`ifdef MASK_SEQ_LOOP_EN
    exp_q = '{8'h01, 8'h0F, 8'h01, 8'h0F, 8'h01, 8'h0F};
    check_trace("loop_mask");
    check("loop_done_pass1", 32'(dtrace[2]), 32'h1);
    check("loop_done_mid", 32'(dtrace[3]), 32'h0);
    check("loop_done_pass2", 32'(dtrace[4]), 32'h1);
`else
    exp_q = '{8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    check_trace("short_mask");
    check("short_done", 32'(dtrace[2]), 32'h1);
    check("short_done_once", 32'(dtrace[4]), 32'h0);
`endif
    to_idle();

    // reset held two cycles mid-run, then table must read back cleared
    write_entry(0, 8'h5A, 3);
    start_run(0); tick();
    reset = 1'b1; tick();
    check("midrst_mask", 32'(bus.mask_out), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_cur_idx", 32'(bus.cur_idx), 32'h0);
    tick(); reset = 1'b0;
    start_run(0);
    check("cleared_mask", 32'(bus.mask_out), 32'h0);
    check("cleared_busy", 32'(bus.busy), 32'h1);
    tick();
    check("cleared_done", 32'(bus.done), 32'h1);
    to_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
